// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Purpose:
//   Turns an asynchronous, bouncy mechanical input into a clean, clock-
//   synchronous level plus single-cycle rise/fall pulses. The input passes
//   through a 2-flop synchronizer. A new level is accepted only after
//   STABLE_CYCLES consecutive identical synchronized samples.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical samples needed to accept a level
//                   (legal range 2 .. 2**CNT_W-1)
//   CNT_W         - stability counter width in bits
//
// Ports:
//   clk        in   system clock, all state on posedge
//   reset_n    in   asynchronous active-low reset, clears all state
//   raw_in     in   asynchronous bouncy input
//   level_out  out  debounced level (registered)
//   rise_pulse out  one-cycle pulse on level 0->1 (registered)
//   fall_pulse out  one-cycle pulse on level 1->0 (registered)
//   busy       out  high while a candidate transition is qualifying (registered)
// -----------------------------------------------------------------------------
module debounce_edge #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Entering a WAIT state already counts the first matching sample, so the
    // last sample of a qualification is seen when cnt_q == STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           state_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE_LOW;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Synchronizer: only sync2_q is ever looked at by the FSM.
            sync1_q <= raw_in;
            sync2_q <= sync1_q;

            // Pulses last a single cycle unless a qualification completes now.
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;

            case (state_q)
                IDLE_LOW: begin
                    if (sync2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                    end
                end

                WAIT_HIGH: begin
                    if (!sync2_q) begin
                        // Bounce: abandon without touching level or pulses.
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                    end
                end

                WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule
